// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in, 3x3 window out, for pixel_window_3x3.
// win_row/win_col exist only with PIXEL_WINDOW_COORD_EN.
interface pixel_window_3x3_if
`ifdef PIXEL_WINDOW_COORD_EN
  #(parameter int CW = 13)
`endif
  ;

   logic        in_valid;
   logic [7:0]  in_pixel;
   logic        win_valid;
   logic [71:0] win_pixels;
   logic        frame_done;

`ifdef PIXEL_WINDOW_COORD_EN
   logic [CW-1:0] win_row;
   logic [CW-1:0] win_col;

   modport master (
      output in_valid,
      output in_pixel,
      input  win_valid,
      input  win_pixels,
      input  frame_done,
      input  win_row,
      input  win_col
   );

   modport slave (
      input  in_valid,
      input  in_pixel,
      output win_valid,
      output win_pixels,
      output frame_done,
      output win_row,
      output win_col
   );
`else
   modport master (
      output in_valid,
      output in_pixel,
      input  win_valid,
      input  win_pixels,
      input  frame_done
   );

   modport slave (
      input  in_valid,
      input  in_pixel,
      output win_valid,
      output win_pixels,
      output frame_done
   );
`endif

endinterface

// File: rtl/pixel_window_3x3.sv
// 3x3 neighbourhood builder over two line buffers, 1-cycle latency.
// Optional centre coordinates: define PIXEL_WINDOW_COORD_EN.
module pixel_window_3x3 #(
   parameter int IMG_W = 800,
   parameter int IMG_H = 600,
   parameter int CW    = 13
) (
   input logic clock,
   input logic reset_n,
   pixel_window_3x3_if.slave bus
);

   localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

   logic          acc;
   logic [CW-1:0] col_q;
   logic [CW-1:0] col_d;
   logic [CW-1:0] row_q;
   logic [CW-1:0] row_d;
   logic          last_col;
   logic          last_row;
   logic [AW-1:0] addr;

   assign acc      = bus.in_valid;
   assign last_col = (col_q == CW'(IMG_W - 1));
   assign last_row = (row_q == CW'(IMG_H - 1));
   assign addr     = col_q[AW-1:0];

   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (acc) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   // LB0 holds row-1, LB1 holds row-2; contents never reset.
   logic [7:0] lb0_mem [IMG_W];
   logic [7:0] lb1_mem [IMG_W];
   logic [7:0] a;
   logic [7:0] b;

   assign a = lb0_mem[addr];
   assign b = lb1_mem[addr];

   always_ff @(posedge clock) begin
      if (acc) begin
         lb0_mem[addr] <= bus.in_pixel;
         lb1_mem[addr] <= a;
      end
   end

   // Column regs: [2]=top, [1]=middle, [0]=bottom.
   logic [2:0][7:0] colL_q;
   logic [2:0][7:0] colC_q;
   logic [2:0][7:0] colR_q;
   logic [2:0][7:0] colL_d;
   logic [2:0][7:0] colC_d;
   logic [2:0][7:0] colR_d;

   always_comb begin
      colL_d = colL_q;
      colC_d = colC_q;
      colR_d = colR_q;
      if (acc) begin
         colL_d = colC_q;
         colC_d = colR_q;
         colR_d = {b, a, bus.in_pixel};
      end
   end

   logic        fire;
   logic        fin;
   logic [71:0] win_d;

   assign fire = acc
              && (row_q >= CW'(2))
              && (col_q >= CW'(2));
   assign fin  = acc && last_row && last_col;

   assign win_d = {colL_d[2], colC_d[2], colR_d[2],
                   colL_d[1], colC_d[1], colR_d[1],
                   colL_d[0], colC_d[0], colR_d[0]};

   logic        win_valid_q;
   logic        frame_done_q;
   logic [71:0] win_pixels_q;
   logic [71:0] win_pixels_d;

   assign win_pixels_d = fire ? win_d : win_pixels_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         col_q        <= '0;
         row_q        <= '0;
         colL_q       <= '0;
         colC_q       <= '0;
         colR_q       <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         win_pixels_q <= '0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         colL_q       <= colL_d;
         colC_q       <= colC_d;
         colR_q       <= colR_d;
         win_valid_q  <= fire;
         frame_done_q <= fin;
         win_pixels_q <= win_pixels_d;
      end
   end

   assign bus.win_valid  = win_valid_q;
   assign bus.frame_done = frame_done_q;
   assign bus.win_pixels = win_pixels_q;

`ifdef PIXEL_WINDOW_COORD_EN
   logic [CW-1:0] win_row_q;
   logic [CW-1:0] win_col_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         win_row_q <= '0;
         win_col_q <= '0;
      end else if (fire) begin
         win_row_q <= row_q - 1'b1;
         win_col_q <= col_q - 1'b1;
      end
   end

   assign bus.win_row = win_row_q;
   assign bus.win_col = win_col_q;
`endif

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Scoreboarded bench for pixel_window_3x3 on an 8x6 image.
// Windows are predicted from a stored copy of the frame.
module tb_pixel_window_3x3;

   localparam int W  = 8;
   localparam int H  = 6;
   localparam int CW = 13;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   pixel_window_3x3_if bus ();

   pixel_window_3x3 #(
      .IMG_W(W),
      .IMG_H(H),
      .CW   (CW)
   ) dut (
      .clock  (clk),
      .reset_n(rst_n),
      .bus    (bus.slave)
   );

   typedef struct packed {
      logic [71:0]   px;
      logic          fd;
      logic [CW-1:0] r;
      logic [CW-1:0] c;
   } exp_t;

   exp_t        sbq[$];
   logic [7:0]  img [H][W];
   int          errors = 0;
   int          checks = 0;
   bit          exp_fire = 1'b0;
   logic [71:0] last_win = '0;
   logic [71:0] first_win = '0;
   logic [71:0] last_obs = '0;
   int          pulses = 0;
   int          fd_cnt = 0;
   logic [CW-1:0] first_r = '0;
   logic [CW-1:0] first_c = '0;
   logic [CW-1:0] last_r = '0;
   logic [CW-1:0] last_c = '0;

   task automatic chk(input string tag, input logic [71:0] obs,
                      input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Output monitor, half a cycle after each active edge.
   always @(negedge clk) begin
      exp_t e;
      chk("win_valid", 72'(bus.win_valid), 72'(exp_fire));
      if (bus.win_valid === 1'b1) begin
         chk("sb_nonempty", 72'(sbq.size() != 0), 72'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("win_pixels", bus.win_pixels, e.px);
            chk("frame_done", 72'(bus.frame_done), 72'(e.fd));
`ifdef PIXEL_WINDOW_COORD_EN
            chk("win_row", 72'(bus.win_row), 72'(e.r));
            chk("win_col", 72'(bus.win_col), 72'(e.c));
            if (pulses == 0) begin
               first_r = bus.win_row;
               first_c = bus.win_col;
            end
            last_r = bus.win_row;
            last_c = bus.win_col;
`endif
            last_win = e.px;
         end
         if (pulses == 0) first_win = bus.win_pixels;
         last_obs = bus.win_pixels;
         if (bus.frame_done === 1'b1) fd_cnt++;
         pulses++;
      end else begin
         chk("hold_pixels", bus.win_pixels, last_win);
         chk("frame_done_idle", 72'(bus.frame_done), 72'd0);
      end
   end

   task automatic step(input bit v, input logic [7:0] p, input bit fire);
      @(negedge clk);
      #1;
      bus.in_valid = v;
      bus.in_pixel = p;
      exp_fire     = fire;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
   endtask

   task automatic accept(input int r, input int c, input logic [7:0] p);
      exp_t e;
      bit   fire;
      img[r][c] = p;
      fire = (r >= 2) && (c >= 2);
      if (fire) begin
         e.px = '0;
         for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
               e.px = {e.px[63:0], img[r-2+dr][c-2+dc]};
         e.fd = (r == H - 1) && (c == W - 1);
         e.r  = CW'(r - 1);
         e.c  = CW'(c - 1);
         sbq.push_back(e);
      end
      step(1'b1, p, fire);
   endtask

   task automatic frame(input bit inv, input int gap, input int stall_r,
                        input int stop_r, input int stop_c);
      int v;
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            while (gap > 0 && int'($urandom_range(99)) < gap)
               step(1'b0, 8'($urandom), 1'b0);
            if (r == stall_r && c == 3) idle(100);
            v = r * 16 + c;
            accept(r, c, inv ? 8'(255 - v) : 8'(v));
            if (r == 0 && c == 0) begin
               pulses = 0;
               fd_cnt = 0;
            end
            if (r == stop_r && c == stop_c) return;
         end
      end
   endtask

   localparam logic [71:0] RAMP_FIRST = 72'h00_01_02_10_11_12_20_21_22;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_pixel = 8'h00;
      idle(3);
      chk("rst_win_valid", 72'(bus.win_valid), 72'd0);
      chk("rst_frame_done", 72'(bus.frame_done), 72'd0);
      chk("rst_win_pixels", bus.win_pixels, 72'd0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;

      // Ramp frame
      frame(1'b0, 0, -1, -1, -1);
      idle(3);
      chk("s1_pulses", 72'(pulses), 72'd24);
      chk("s1_first", first_win, RAMP_FIRST);
      chk("s1_last_br", 72'(last_obs[7:0]), 72'h57);
      chk("s1_fd_cnt", 72'(fd_cnt), 72'd1);
      chk("s1_sb_drained", 72'(sbq.size()), 72'd0);
`ifdef PIXEL_WINDOW_COORD_EN
      chk("s6_first_rc", 72'({first_r, first_c}), 72'({CW'(1), CW'(1)}));
      chk("s6_last_rc", 72'({last_r, last_c}), 72'({CW'(4), CW'(6)}));
`endif

      // Gapped input
      frame(1'b0, 40, -1, -1, -1);
      idle(3);
      chk("s2_pulses", 72'(pulses), 72'd24);
      chk("s2_first", first_win, RAMP_FIRST);
      chk("s2_last_br", 72'(last_obs[7:0]), 72'h57);
      chk("s2_sb_drained", 72'(sbq.size()), 72'd0);

      // Back-to-back frames, second inverted
      frame(1'b0, 0, -1, -1, -1);
      frame(1'b1, 0, -1, -1, -1);
      idle(3);
      chk("s3_pulses", 72'(pulses), 72'd24);
      chk("s3_first_tl", 72'(first_win[71:64]), 72'hFF);
      chk("s3_last_br", 72'(last_obs[7:0]), 72'(8'hFF - 8'h57));
      chk("s3_sb_drained", 72'(sbq.size()), 72'd0);

      // Async reset mid-frame
      frame(1'b0, 0, -1, 3, 4);
      @(negedge clk);
      #2;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      exp_fire     = 1'b0;
      #1;
      chk("s4_rst_valid", 72'(bus.win_valid), 72'd0);
      chk("s4_rst_pixels", bus.win_pixels, 72'd0);
      last_win = '0;
      sbq.delete();
      idle(2);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      frame(1'b0, 0, -1, -1, -1);
      idle(3);
      chk("s4_pulses", 72'(pulses), 72'd24);
      chk("s4_first", first_win, RAMP_FIRST);
      chk("s4_last_br", 72'(last_obs[7:0]), 72'h57);
      chk("s4_sb_drained", 72'(sbq.size()), 72'd0);

      // Long idle mid-row
      frame(1'b0, 0, 3, -1, -1);
      idle(3);
      chk("s5_pulses", 72'(pulses), 72'd24);
      chk("s5_sb_drained", 72'(sbq.size()), 72'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_window_3x3.md
Name: pixel_window_3x3

Overview:
- Downstream of the static-image blanking stage. Consumes its gated 8-bit pixel stream, accepting only pixels qualified by that stage's ready strobe.
- Builds a 3x3 neighbourhood window per active pixel using two on-chip line buffers.
- Feeds the feature-detection kernels (corner/gradient) that need a full 3x3 neighbourhood around each centre pixel.

Parameters:
- IMG_W, 800, active pixels per row; line buffer depth.
- IMG_H, 600, active rows per frame.
- CW, 13, width of internal row/col counters and coordinate outputs.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel strobe; driven from the blanking stage's ready output.
- in_pixel  in  8  pixel value; driven from the blanking stage's pixelout.
- win_valid  out  1  one-cycle pulse; win_pixels holds a complete window.
- win_pixels  out  72  3x3 window, row-major, top-left in [71:64], bottom-right in [7:0].
- frame_done  out  1  one-cycle pulse coincident with the last window of a frame.

Behaviour:
- Clock and reset:
  - One clock.
  - reset_n is asynchronous and active-low: assertion clears state immediately; deassertion is synchronous to clock.
- Reset values:
  - Outputs: win_valid=0, frame_done=0, win_pixels=0.
  - Internal: col=0, row=0, window shift registers=0.
  - Line-buffer RAM contents are not reset; stale data is masked by the row/col qualification below.
- Accept:
  - A pixel is accepted on any rising edge with in_valid=1.
  - No backpressure; every strobe must be consumed. in_valid may be high on consecutive cycles.
  - in_pixel is ignored when in_valid=0, and no state changes.
- Counters: the accepted pixel sits at position (row,col).
  - After accept, col increments.
  - At col==IMG_W-1, col wraps to 0 and row increments.
  - At row==IMG_H-1 and col==IMG_W-1, both wrap to 0 (next frame).
- Line buffers: LB0 holds row-1 and LB1 holds row-2, each IMG_W x 8. On accept at col:
  - Read a=LB0[col] and b=LB1[col].
  - Write LB0[col]<=in_pixel and LB1[col]<=a (read-before-write at the same address within the cycle).
- Window shift:
  - On accept, the three 8-bit column registers per row shift left.
  - The new right column is {b (top), a (middle), in_pixel (bottom)}.
  - Registers do not shift without an accept.
- Output timing:
  - Latency is 1 cycle: win_valid is registered and asserts the cycle after an accept at which row>=2 and col>=2.
  - The window is centred on (row-1,col-1).
  - win_pixels updates together with win_valid and holds its value while win_valid=0.
- Borders:
  - No windows are produced for centre pixels on the outer 1-pixel border.
  - Output is (IMG_W-2)*(IMG_H-2) windows per frame; 798*598=477204 at default parameters.
- Frame end:
  - frame_done asserts with win_valid for the accept at (IMG_H-1, IMG_W-1).
- Frame and row boundaries:
  - Rows 0 and 1 of a new frame produce no windows, so the previous frame's stale LB data is never emitted.
  - Columns 0-1 of each row refill the shift registers; the previous row's right-edge data is never emitted.
- Reset mid-frame: the next accepted pixel after deassertion is treated as (0,0).

Optional Feature:
- Macro: PIXEL_WINDOW_COORD_EN.
- Defined:
  - Adds outputs win_row[CW-1:0] and win_col[CW-1:0], giving the centre coordinates (row-1, col-1).
  - Both are registered alongside win_pixels and reset to 0.
- Undefined: the ports are absent and there is no coordinate logic.

Test Plan:
- Run with IMG_W=8, IMG_H=6.
- Scenario 1, ramp frame:
  - Stimulus: continuous in_valid, pixel=row*16+col.
  - Response: 24 win_valid pulses.
  - First window is 0x00,01,02,10,11,12,20,21,22, one cycle after accept (2,2).
  - Last window has bottom-right 0x57, with frame_done high on that same cycle.
- Scenario 2, gapped input:
  - Stimulus: same frame, in_valid toggling 1/0 pseudo-randomly.
  - Response: window sequence identical to scenario 1; no pulse on any cycle not following an accept.
- Scenario 3, back-to-back frames:
  - Stimulus: frame 2 uses pixel=0xFF-(row*16+col).
  - Response: no window emitted during frame-2 rows 0-1.
  - Frame-2 first window top-left is 0xFF; frame-1 data never appears.
- Scenario 4, async reset mid-frame:
  - Stimulus: assert reset_n=0 at (3,4), mid-cycle.
  - Response: win_valid and win_pixels go to 0 immediately.
  - After release, a new full frame yields the exact 24-window sequence of scenario 1.
- Scenario 5, idle:
  - Stimulus: hold in_valid=0 for 100 cycles mid-row.
  - Response: win_valid stays 0 and win_pixels is unchanged.
- Scenario 6, PIXEL_WINDOW_COORD_EN defined:
  - Response: first window reports (win_row,win_col)=(1,1) and last reports (4,6).
